// File: rtl/prbs_ber_seq.sv
// BER measurement sequencer: resets the PRBS checker, waits for lock, then counts
// checked bits and errors over a programmed window with bounded retry on failure.
module prbs_ber_seq #(
  parameter int CNT_W       = 32,
  parameter int ERR_W       = 16,
  parameter int RST_CYCLES  = 4,
  parameter int ACQ_TIMEOUT = 2048,
  parameter int MAX_RETRY   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_window,
  input  logic [ERR_W-1:0] cfg_err_limit,
  input  logic             chk_sync,
  input  logic             bit_vld,
  input  logic             bit_err,
  output logic             chk_rst_n,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [1:0]       fail_code,
  output logic [CNT_W-1:0] bit_total,
  output logic [ERR_W-1:0] err_total,
  output logic [2:0]       retry_cnt,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHK_RST = 3'd1,
    ACQUIRE = 3'd2,
    MEASURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam int ACQ_W = $clog2(ACQ_TIMEOUT);
  localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RST_CYCLES - 1);
  localparam logic [ACQ_W-1:0] ACQ_LAST  = ACQ_W'(ACQ_TIMEOUT - 1);
  localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRY);
  localparam logic [1:0] FC_NONE  = 2'd0;
  localparam logic [1:0] FC_ACQ   = 2'd1;
  localparam logic [1:0] FC_SYNC  = 2'd2;
  localparam logic [1:0] FC_ABORT = 2'd3;

  state_t           st;
  logic [RST_W-1:0] rst_cnt;
  logic [ACQ_W-1:0] acq_cnt;
  logic [CNT_W-1:0] window;
  logic [ERR_W-1:0] err_limit;
  logic [CNT_W-1:0] bits_next;
  logic [ERR_W-1:0] errs_next;
  logic             win_end;
  logic             fail_now;
  logic [1:0]       fail_cause;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign bits_next = bit_total + 1'b1;
  assign errs_next = bit_err ? sat_inc(err_total) : err_total;
  assign win_end   = bit_vld && (bits_next == window);

  // Window completion outranks a simultaneous loss of sync.
  always_comb begin
    fail_now   = 1'b0;
    fail_cause = FC_NONE;
    if (st == ACQUIRE && !chk_sync && acq_cnt == ACQ_LAST) begin
      fail_now   = 1'b1;
      fail_cause = FC_ACQ;
    end
    if (st == MEASURE && !chk_sync && !win_end) begin
      fail_now   = 1'b1;
      fail_cause = FC_SYNC;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= IDLE;
      rst_cnt   <= '0;
      acq_cnt   <= '0;
      window    <= '0;
      err_limit <= '0;
      pass      <= 1'b0;
      fail_code <= FC_NONE;
      bit_total <= '0;
      err_total <= '0;
      retry_cnt <= '0;
    end else if (abort && (st == CHK_RST || st == ACQUIRE || st == MEASURE)) begin
      st        <= DONE;
      pass      <= 1'b0;
      fail_code <= FC_ABORT;
    end else if (fail_now) begin
      if (retry_cnt < RETRY_MAX) begin
        retry_cnt <= retry_cnt + 1'b1;
        bit_total <= '0;
        err_total <= '0;
        rst_cnt   <= '0;
        st        <= CHK_RST;
      end else begin
        st        <= DONE;
        pass      <= 1'b0;
        fail_code <= fail_cause;
      end
    end else begin
      case (st)
        IDLE: begin
          if (start) begin
            window    <= (cfg_window == '0) ? CNT_W'(1) : cfg_window;
            err_limit <= cfg_err_limit;
            bit_total <= '0;
            err_total <= '0;
            pass      <= 1'b0;
            fail_code <= FC_NONE;
            retry_cnt <= '0;
            rst_cnt   <= '0;
            st        <= CHK_RST;
          end
        end
        CHK_RST: begin
          if (rst_cnt == RST_LAST) begin
            acq_cnt <= '0;
            st      <= ACQUIRE;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        ACQUIRE: begin
          if (chk_sync) st <= MEASURE;
          else          acq_cnt <= acq_cnt + 1'b1;
        end
        MEASURE: begin
          if (bit_vld) begin
            bit_total <= bits_next;
            err_total <= errs_next;
            if (win_end) begin
              pass      <= (errs_next <= err_limit);
              fail_code <= FC_NONE;
              st        <= DONE;
            end
          end
        end
        DONE:    st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

  assign chk_rst_n = (st != CHK_RST);
  assign busy      = (st != IDLE);
  assign done      = (st == DONE);
  assign state     = st;

endmodule

// File: tb/tb_prbs_ber_seq.sv
// Bench for prbs_ber_seq: directed scenario table, hand-written corner sequences
// and randomized traffic, all checked against a behavioural model.
module tb_prbs_ber_seq;
  localparam int CNT_W       = 32;
  localparam int ERR_W       = 4;
  localparam int RST_CYCLES  = 4;
  localparam int ACQ_TIMEOUT = 16;
  localparam int MAX_RETRY   = 2;
  localparam int ERR_MAX     = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, abort, chk_sync, bit_vld, bit_err;
  logic [CNT_W-1:0] cfg_window;
  logic [ERR_W-1:0] cfg_err_limit;
  logic             chk_rst_n, busy, done, pass;
  logic [1:0]       fail_code;
  logic [CNT_W-1:0] bit_total;
  logic [ERR_W-1:0] err_total;
  logic [2:0]       retry_cnt;
  logic [2:0]       state;

  prbs_ber_seq #(
    .CNT_W(CNT_W), .ERR_W(ERR_W), .RST_CYCLES(RST_CYCLES),
    .ACQ_TIMEOUT(ACQ_TIMEOUT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_window(cfg_window), .cfg_err_limit(cfg_err_limit),
    .chk_sync(chk_sync), .bit_vld(bit_vld), .bit_err(bit_err),
    .chk_rst_n(chk_rst_n), .busy(busy), .done(done), .pass(pass),
    .fail_code(fail_code), .bit_total(bit_total), .err_total(err_total),
    .retry_cnt(retry_cnt), .state(state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 checker reset, 2 acquire, 3 measure, 4 done
  int     m_state, m_rc, m_ac, m_lim, m_bits, m_errs, m_retry, m_pass, m_fc;
  longint m_win;

  task automatic m_reset();
    m_state = 0; m_rc = 0; m_ac = 0; m_win = 0; m_lim = 0;
    m_bits = 0; m_errs = 0; m_retry = 0; m_pass = 0; m_fc = 0;
  endtask

  task automatic m_fail(input int cause);
    if (m_retry < MAX_RETRY) begin
      m_retry++; m_bits = 0; m_errs = 0; m_rc = 0; m_state = 1;
    end else begin
      m_state = 4; m_pass = 0; m_fc = cause;
    end
  endtask

  task automatic m_step();
    bit complete;
    if (abort && m_state >= 1 && m_state <= 3) begin
      m_state = 4; m_pass = 0; m_fc = 3;
      return;
    end
    case (m_state)
      0: if (start) begin
        m_win = (cfg_window == 0) ? 1 : longint'(cfg_window);
        m_lim = int'(cfg_err_limit);
        m_bits = 0; m_errs = 0; m_pass = 0; m_fc = 0; m_retry = 0; m_rc = 0;
        m_state = 1;
      end
      1: begin
        m_rc++;
        if (m_rc == RST_CYCLES) begin m_state = 2; m_ac = 0; end
      end
      2: begin
        if (chk_sync) m_state = 3;
        else if (m_ac == ACQ_TIMEOUT - 1) m_fail(1);
        else m_ac++;
      end
      3: begin
        complete = bit_vld && (longint'(m_bits + 1) == m_win);
        if (!chk_sync && !complete) m_fail(2);
        else if (bit_vld) begin
          m_bits++;
          if (bit_err) m_errs = (m_errs + 1 > ERR_MAX) ? ERR_MAX : m_errs + 1;
          if (complete) begin m_state = 4; m_pass = (m_errs <= m_lim); m_fc = 0; end
        end
      end
      default: m_state = 0;
    endcase
  endtask

  function automatic logic [63:0] exp_vec();
    return {16'd0, 3'(m_state), (m_state != 1), (m_state != 0), (m_state == 4),
            1'(m_pass), 2'(m_fc), 32'(m_bits), 4'(m_errs), 3'(m_retry)};
  endfunction

  function automatic logic [63:0] act_vec();
    return {16'd0, state, chk_rst_n, busy, done, pass, fail_code, bit_total, err_total, retry_cnt};
  endfunction

  task automatic tick();
    m_step();
    @(posedge clk); #1;
    chk("cycle", act_vec(), exp_vec());
  endtask

  task automatic idle_inputs();
    start = 0; abort = 0; chk_sync = 0; bit_vld = 0; bit_err = 0;
  endtask

  typedef struct {
    int window; int limit; int sync_delay; int n_err; int drop_at; int max_bits; int abort_at;
    int e_pass; int e_fc; int e_bits; int e_errs; int e_retry; int e_rstlow;
  } scn_t;

  scn_t tbl[9];

  task automatic run_scn(input int idx, input scn_t s);
    int acq_c, sent, meas_c, rstlow;
    bit fin;
    acq_c = 0; sent = 0; meas_c = 0; rstlow = 0; fin = 0;
    idle_inputs();
    cfg_window = CNT_W'(s.window); cfg_err_limit = ERR_W'(s.limit);
    start = 1; tick(); start = 0;
    if (chk_rst_n === 1'b0) rstlow++;
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      chk_sync = 0; bit_vld = 0; bit_err = 0; abort = 0;
      case (m_state)
        1: begin acq_c = 0; sent = 0; meas_c = 0; end
        2: begin chk_sync = (s.sync_delay >= 0 && acq_c >= s.sync_delay); acq_c++; end
        3: begin
          chk_sync = 1;
          if (s.abort_at >= 0 && meas_c == s.abort_at) abort = 1;
          else if (s.drop_at >= 0 && m_retry == 0 && sent >= s.drop_at) chk_sync = 0;
          else if (sent < s.max_bits) begin
            bit_vld = 1; bit_err = (sent < s.n_err); sent++;
          end
          meas_c++;
        end
        default: ;
      endcase
      tick();
      if (chk_rst_n === 1'b0) rstlow++;
      if (done === 1'b1) fin = 1;
    end
    chk($sformatf("s%0d_done_seen", idx), 64'(fin), 64'd1);
    chk($sformatf("s%0d_pass", idx), 64'(pass), 64'(s.e_pass));
    chk($sformatf("s%0d_fail_code", idx), 64'(fail_code), 64'(s.e_fc));
    chk($sformatf("s%0d_bit_total", idx), 64'(bit_total), 64'(s.e_bits));
    chk($sformatf("s%0d_err_total", idx), 64'(err_total), 64'(s.e_errs));
    chk($sformatf("s%0d_retry_cnt", idx), 64'(retry_cnt), 64'(s.e_retry));
    chk($sformatf("s%0d_chk_rst_low", idx), 64'(rstlow), 64'(s.e_rstlow));
    idle_inputs();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit fin;
    bit sync_r;
    //            win  lim  sd  err drop  maxb  abt | pass fc bits errs retry rstlow
    tbl[0] = '{100,  0, 10,  0,  -1, 1000,  -1,  1, 0, 100,  0, 0,  4};
    tbl[1] = '{100,  2,  5,  3,  -1, 1000,  -1,  0, 0, 100,  3, 0,  4};
    tbl[2] = '{100,  2,  5,  2,  -1, 1000,  -1,  1, 0, 100,  2, 0,  4};
    tbl[3] = '{100,  0, -1,  0,  -1, 1000,  -1,  0, 1,   0,  0, 2, 12};
    tbl[4] = '{100,  0,  3,  0,  50, 1000,  -1,  1, 0, 100,  0, 1,  8};
    tbl[5] = '{100,  0,  2,  0,  -1,    3,   5,  0, 3,   3,  0, 0,  4};
    tbl[6] = '{  0,  0,  0,  0,  -1, 1000,  -1,  1, 0,   1,  0, 0,  4};
    tbl[7] = '{ 30, 15,  1, 20,  -1, 1000,  -1,  1, 0,  30, 15, 0,  4};
    tbl[8] = '{ 30, 14,  1, 20,  -1, 1000,  -1,  0, 0,  30, 15, 0,  4};

    idle_inputs();
    cfg_window = '0; cfg_err_limit = '0;
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    m_reset();
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_chk_rst_n", 64'(chk_rst_n), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);
    chk("rst_fail_code", 64'(fail_code), 64'd0);
    chk("rst_bit_total", 64'(bit_total), 64'd0);
    chk("rst_err_total", 64'(err_total), 64'd0);
    chk("rst_retry_cnt", 64'(retry_cnt), 64'd0);
    rst = 1;
    tick();

    for (int i = 0; i < 9; i++) run_scn(i, tbl[i]);

    // Abort in IDLE is ignored; start wins over a simultaneous abort.
    abort = 1; tick(); abort = 0;
    chk("idle_abort_state", 64'(state), 64'd0);
    cfg_window = 5; cfg_err_limit = 0;
    start = 1; abort = 1; tick(); start = 0; abort = 0;
    chk("start_over_abort", 64'(state), 64'd1);
    tick();
    cfg_window = 7; start = 1; tick(); start = 0;
    chk_sync = 1; fin = 0;
    for (int i = 0; i < 100 && !fin; i++) begin
      bit_vld = (m_state == 3); tick();
      if (done === 1'b1) fin = 1;
    end
    chk("busy_start_done", 64'(fin), 64'd1);
    chk("busy_start_ignored", 64'(bit_total), 64'd5);
    idle_inputs(); tick();

    // Asynchronous reset in the middle of a measurement.
    cfg_window = 100; start = 1; tick(); start = 0; chk_sync = 1;
    for (int i = 0; i < 40; i++) begin
      bit_vld = (m_state == 3); bit_err = bit_vld && (i % 3 == 0); tick();
    end
    chk("pre_rst_measure", 64'(state), 64'd3);
    #2 rst = 0;
    #1;
    m_reset();
    chk("midrst_state", 64'(state), 64'd0);
    chk("midrst_chk_rst_n", 64'(chk_rst_n), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_bit_total", 64'(bit_total), 64'd0);
    chk("midrst_err_total", 64'(err_total), 64'd0);
    chk("midrst_outputs", act_vec(), exp_vec());
    idle_inputs();
    @(posedge clk); #1;
    rst = 1;
    tick();

    // Randomized traffic against the model.
    sync_r = 1;
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 19) == 0);
      abort = (m_state >= 1 && m_state <= 3) && ($urandom_range(0, 59) == 0);
      cfg_window = CNT_W'($urandom_range(0, 40));
      cfg_err_limit = ERR_W'($urandom_range(0, ERR_MAX));
      if (sync_r ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 5) == 0)) sync_r = ~sync_r;
      chk_sync = sync_r;
      bit_vld = sync_r && ($urandom_range(0, 1) == 1);
      bit_err = bit_vld && ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
